// File: rtl/bus_xfer_scheduler.sv
// Round-robin scheduler that moves head packets from device FIFOs onto a shared packet bus.
// Define BUS_XFER_STATS_EN to add saturating xfer_cnt / bcast_cnt / drop_cnt outputs.
module bus_xfer_scheduler #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  localparam int        idw       = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [idw-1:0]           grant_id,
  output logic                     drop
`ifdef BUS_XFER_STATS_EN
  ,
  output logic [31:0]              xfer_cnt,
  output logic [31:0]              bcast_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  // state | meaning
  // IDLE  | search pndng round-robin from last+1, latch grant_id
  // POP   | re-check granted pndng, strobe pop and capture its head packet
  // PUSH  | drive D_push and the decoded push mask (or drop), then back to IDLE
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t               state;
  logic [idw-1:0]       last;
  logic [idw-1:0]       rr_gnt;
  logic [idw-1:0]       rr_idx;
  logic                 rr_hit;
  logic [pckg_sz-1:0]   pkt;
  logic [7:0]           dst;
  logic                 is_bcast;
  logic                 is_uni;
  logic [drvrs-1:0]     gnt_oh;

  assign dst      = pkt[pckg_sz-1 -: 8];
  assign is_bcast = (dst == broadcast);
  assign is_uni   = !is_bcast && (int'(dst) < drvrs);
  assign gnt_oh   = drvrs'(1) << grant_id;
  assign busy     = (state != IDLE);

  always_comb begin
    rr_gnt = last;
    rr_idx = last;
    rr_hit = 1'b0;
    for (int i = 1; i <= drvrs; i++) begin
      rr_idx = idw'((int'(last) + i) % drvrs);
      if (!rr_hit && pndng[rr_idx]) begin
        rr_gnt = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= idw'(drvrs - 1);
      grant_id <= '0;
      pkt      <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      drop     <= 1'b0;
    end else begin
      pop  <= '0;
      push <= '0;
      drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rr_hit) begin
            grant_id <= rr_gnt;
            state    <= POP;
          end
        end
        POP: begin
          // a pending flag that fell after the grant aborts without moving the pointer
          if (pndng[grant_id]) begin
            pop   <= gnt_oh;
            pkt   <= D_pop[int'(grant_id)*pckg_sz +: pckg_sz];
            last  <= grant_id;
            state <= PUSH;
          end else begin
            state <= IDLE;
          end
        end
        PUSH: begin
          D_push <= pkt;
          if (is_bcast)    push <= ~gnt_oh;
          else if (is_uni) push <= drvrs'(1) << dst;
          else             drop <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_XFER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt  <= '0;
      bcast_cnt <= '0;
      drop_cnt  <= '0;
    end else if (state == PUSH) begin
      if ((is_bcast || is_uni) && (xfer_cnt != '1)) xfer_cnt  <= xfer_cnt + 32'd1;
      if (is_bcast && (bcast_cnt != '1))           bcast_cnt <= bcast_cnt + 32'd1;
      if (!is_bcast && !is_uni && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_xfer_scheduler.sv
// Bench for bus_xfer_scheduler: directed scenarios plus random FIFO drain against a queue-level model.
// Compile with BUS_XFER_STATS_EN to also check the statistics counters.
module tb_bus_xfer_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng;
  logic [N*W-1:0] D_pop;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [W-1:0]   D_push;
  logic           busy;
  logic [1:0]     grant_id;
  logic           drop;
`ifdef BUS_XFER_STATS_EN
  logic [31:0]    xfer_cnt;
  logic [31:0]    bcast_cnt;
  logic [15:0]    drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_xfer_scheduler #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop     (drop)
`ifdef BUS_XFER_STATS_EN
    ,
    .xfer_cnt (xfer_cnt),
    .bcast_cnt(bcast_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // device FIFO contents for the random phase
  logic [W-1:0] mem [N][8];
  int hd  [N];
  int cnt [N];

  typedef struct {
    int           dev;
    logic [W-1:0] pkt;
    logic [N-1:0] mask;
    bit           drp;
  } xfer_t;
  xfer_t expq[$];

  task automatic drive_fifos();
    for (int d = 0; d < N; d++) begin
      pndng[d] = (hd[d] < cnt[d]);
      D_pop[d*W +: W] = (hd[d] < cnt[d]) ? mem[d][hd[d]] : 16'hDEAD;
    end
  endtask

  initial begin
    int pop_dev[$];
    int pop_cyc[$];
    int idx_pop, idx_push, last_pop_cyc, m_last, left, d;
    int mc[N];
    int e_x, e_b, e_d;
    logic [7:0] dst;
    xfer_t e;

    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    tick();
    tick();
    chk("rst_pop", pop, 0);
    chk("rst_push", push, 0);
    chk("rst_dpush", D_push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_grant", grant_id, 0);
    reset = 1'b0;

    // unicast 0 -> 2
    D_pop = {$urandom, $urandom};
    D_pop[0*W +: W] = 16'h02AB;
    pndng = 4'b0001;
    tick();
    chk("u_busy_hi", busy, 1);
    chk("u_grant", grant_id, 0);
    chk("u_nopop_yet", pop, 0);
    tick();
    chk("u_pop", pop, 4'b0001);
    pndng = '0;
    tick();
    chk("u_push", push, 4'b0100);
    chk("u_dpush", D_push, 16'h02AB);
    chk("u_pop_clr", pop, 0);
    tick();
    chk("u_busy_lo", busy, 0);
    chk("u_push_clr", push, 0);

    // broadcast from 2
    D_pop[2*W +: W] = 16'hFF5A;
    pndng = 4'b0100;
    tick();
    tick();
    chk("b_pop", pop, 4'b0100);
    pndng = '0;
    tick();
    chk("b_push", push, 4'b1011);
    chk("b_dpush", D_push, 16'hFF5A);
    chk("b_drop", drop, 0);
`ifdef BUS_XFER_STATS_EN
    chk("b_bcast_cnt", bcast_cnt, 1);
    chk("b_xfer_cnt", xfer_cnt, 2);
`endif
    tick();

    // invalid destination from 1
    D_pop[1*W +: W] = 16'h07CC;
    pndng = 4'b0010;
    tick();
    chk("i_grant", grant_id, 1);
    tick();
    chk("i_pop", pop, 4'b0010);
    pndng = '0;
    tick();
    chk("i_push", push, 0);
    chk("i_drop", drop, 1);
`ifdef BUS_XFER_STATS_EN
    chk("i_drop_cnt", drop_cnt, 1);
    chk("i_xfer_cnt", xfer_cnt, 2);
`endif
    for (int i = 0; i < N; i++) D_pop[i*W +: W] = 16'h0010 + 16'(i);
    pndng = 4'b1111;
    tick();
    chk("i_drop_1cyc", drop, 0);
    chk("i_next_grant", grant_id, 2);
    tick();
    chk("i_next_pop", pop, 4'b0100);
    pndng = '0;
    tick();
    chk("i_next_push", push, 4'b0001);
    chk("i_next_dpush", D_push, 16'h0012);

    // withdrawn pending on 3 while last = 2
    pndng = 4'b1000;
    tick();
    chk("w_grant", grant_id, 3);
    pndng = '0;
    tick();
    chk("w_nopop", pop, 0);
    chk("w_idle", busy, 0);
    pndng = 4'b1111;
    tick();
    chk("w_last_kept", grant_id, 3);
    pndng = '0;
    tick();
    chk("w_nopop2", pop, 0);
    tick();

    // reset during the push cycle
    D_pop[0*W +: W] = 16'h0123;
    pndng = 4'b0001;
    tick();
    tick();
    chk("r_pop", pop, 4'b0001);
    pndng = '0;
    tick();
    chk("r_push_pre", push, 4'b0010);
    reset = 1'b1;
    #1;
    chk("r_push_async", push, 0);
    chk("r_busy_async", busy, 0);
    #3;
    reset = 1'b0;

    // round-robin with all pending, everything to device 0
    for (int i = 0; i < N; i++) D_pop[i*W +: W] = 16'h0020 + 16'(i);
    pndng = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 0) chk("r_first_grant", grant_id, 0);
      if (pop != 0) begin
        chk("rr_excl", pop & push, 0);
        for (int k = 0; k < N; k++) if (pop[k]) pop_dev.push_back(k);
        pop_cyc.push_back(c);
      end
    end
    pndng = '0;
    chk("rr_count", pop_dev.size(), 5);
    for (int k = 0; k < pop_dev.size() && k < 5; k++) begin
      chk("rr_dev", pop_dev[k], k % N);
      chk("rr_cyc", pop_cyc[k], 1 + 3 * k);
    end
    tick();
    tick();

    // random drain of preloaded FIFOs against a queue-level model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int q = 0; q < N; q++) begin
      hd[q]  = 0;
      cnt[q] = $urandom_range(1, 6);
      for (int k = 0; k < cnt[q]; k++) begin
        case ($urandom_range(0, 3))
          0:       dst = 8'hFF;
          1, 2:    dst = 8'($urandom_range(0, N - 1));
          default: dst = 8'($urandom_range(N, 254));
        endcase
        mem[q][k] = {dst, 8'($urandom)};
      end
    end
    m_last = N - 1;
    left = 0;
    e_x = 0; e_b = 0; e_d = 0;
    for (int q = 0; q < N; q++) begin mc[q] = 0; left += cnt[q]; end
    while (left > 0) begin
      d = -1;
      for (int s = 1; s <= N && d < 0; s++)
        if (mc[(m_last + s) % N] < cnt[(m_last + s) % N]) d = (m_last + s) % N;
      e.dev  = d;
      e.pkt  = mem[d][mc[d]];
      dst    = e.pkt[W-1 -: 8];
      e.drp  = 1'b0;
      e.mask = '0;
      if (dst == 8'hFF) begin e.mask = ~(4'b0001 << d); e_b++; e_x++; end
      else if (dst < N) begin e.mask = 4'b0001 << dst; e_x++; end
      else begin e.drp = 1'b1; e_d++; end
      expq.push_back(e);
      mc[d]++;
      m_last = d;
      left--;
    end

    drive_fifos();
    idx_pop = 0;
    idx_push = 0;
    last_pop_cyc = -10;
    for (int c = 0; c < 300 && idx_push < expq.size(); c++) begin
      tick();
      if (pop != 0) begin
        chk("rnd_excl", pop & push, 0);
        if (idx_pop < expq.size()) begin
          chk("rnd_pop", pop, 4'b0001 << expq[idx_pop].dev);
          if (idx_pop > 0) chk("rnd_spacing", c - last_pop_cyc, 3);
        end else begin
          chk("rnd_extra_pop", pop, 0);
        end
        for (int k = 0; k < N; k++) if (pop[k]) hd[k]++;
        idx_pop++;
        last_pop_cyc = c;
        drive_fifos();
      end
      if (push != 0 || drop) begin
        e = expq[idx_push];
        chk("rnd_push", push, e.mask);
        chk("rnd_drop", drop, e.drp);
        chk("rnd_dpush", D_push, e.pkt);
        chk("rnd_lat", c - last_pop_cyc, 1);
        idx_push++;
      end
    end
    chk("rnd_done", idx_push, expq.size());
`ifdef BUS_XFER_STATS_EN
    chk("rnd_xfer_cnt", xfer_cnt, e_x);
    chk("rnd_bcast_cnt", bcast_cnt, e_b);
    chk("rnd_drop_cnt", drop_cnt, e_d);
`endif
    tick();
    chk("rnd_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
